// File: rtl/upc_marquee.sv
// UPC item-name marquee: decodes a 3-bit UPC code to a name shown static or scrolling.
// Optional macro UPC_MARQUEE_ERR_BLINK_EN: invalid codes show a blinking "ERR".
module upc_marquee #(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 25_000_000,
   parameter int LETTER_W   = 5
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [2:0]                     upc,
   input  logic                           scroll_en,
   input  logic                           freeze,
   output logic [NUM_DIGITS*LETTER_W-1:0] letters,
   output logic                           valid,
   output logic                           wrap
);

   localparam int MAX_L = 6 + NUM_DIGITS;
   localparam int OFF_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [LETTER_W-1:0] BLANK_CH = LETTER_W'(26);

   typedef enum logic [1:0] {
      ST_BLANK  = 2'd0,
      ST_STATIC = 2'd1,
      ST_SCROLL = 2'd2
   } state_t;

   // Names packed with the first character in the low 5 bits, padded with blanks.
   function automatic logic [29:0] name_bits(input logic [2:0] code);
      case (code)
         3'b000:  name_bits = {5'd26, 5'd18, 5'd6,  5'd20, 5'd17, 5'd3};   // DRUGS
         3'b001:  name_bits = {5'd26, 5'd24, 5'd3,  5'd13, 5'd0,  5'd2};   // CANDY
         3'b011:  name_bits = {5'd26, 5'd26, 5'd15, 5'd0,  5'd14, 5'd18};  // SOAP
         3'b100:  name_bits = {5'd4,  5'd13, 5'd14, 5'd7,  5'd15, 5'd8};   // IPHONE
         3'b101:  name_bits = {5'd26, 5'd3,  5'd8,  5'd14, 5'd17, 5'd3};   // DROID
         3'b110:  name_bits = {5'd26, 5'd26, 5'd18, 5'd3,  5'd4,  5'd11};  // LEDS
         default: name_bits = {6{5'd26}};
      endcase
   endfunction

   function automatic logic [3:0] name_len(input logic [2:0] code);
      case (code)
         3'b000:  name_len = 4'd5;
         3'b001:  name_len = 4'd5;
         3'b011:  name_len = 4'd4;
         3'b100:  name_len = 4'd6;
         3'b101:  name_len = 4'd5;
         3'b110:  name_len = 4'd4;
         default: name_len = 4'd0;
      endcase
   endfunction

   function automatic logic [LETTER_W-1:0] name_char(input logic [2:0] code, input logic [3:0] idx);
      logic [29:0] nb;
      logic [4:0]  c;
      nb = name_bits(code);
      case (idx)
         4'd0:    c = nb[4:0];
         4'd1:    c = nb[9:5];
         4'd2:    c = nb[14:10];
         4'd3:    c = nb[19:15];
         4'd4:    c = nb[24:20];
         4'd5:    c = nb[29:25];
         default: c = 5'd26;
      endcase
      return LETTER_W'(c);
   endfunction

   // Character for digit i; the scroll index wraps with one subtraction since offset+i < 2L.
   function automatic logic [LETTER_W-1:0] digit_char(input state_t st, input logic [2:0] code,
         input logic [OFF_W-1:0] off, input int i, input logic err_on);
      int len;
      int l;
      int p;
      logic [LETTER_W-1:0] ch;
      len = int'(name_len(code));
      l   = len + NUM_DIGITS;
      p   = int'(off) + i;
      if (p >= l) begin
         p = p - l;
      end else begin
         p = p;
      end
      ch = BLANK_CH;
      case (st)
         ST_STATIC: begin
            if (i < len) ch = name_char(code, 4'(i));
            else         ch = BLANK_CH;
         end
         ST_SCROLL: begin
            if (p < len) ch = name_char(code, 4'(p));
            else         ch = BLANK_CH;
         end
         ST_BLANK: begin
            if (err_on && (i == 0))     ch = LETTER_W'(4);
            else if (err_on && (i < 3)) ch = LETTER_W'(17);
            else                        ch = BLANK_CH;
         end
         default: ch = BLANK_CH;
      endcase
      return ch;
   endfunction

   logic [2:0]                     sync1_r, sync2_r, code_r;
   logic                           load_pend_r;
   state_t                         state_r, state_nxt_s;
   logic [OFF_W-1:0]               offset_r, offset_nxt_s;
   logic [DIV_W-1:0]               div_r, div_nxt_s;
   logic                           wrap_r, wrap_nxt_s;
   logic                           valid_r;
   logic [NUM_DIGITS*LETTER_W-1:0] letters_r, disp_s;
   logic                           load_s, mode_chg_s, tick_s, last_s, err_on_s;
   logic [2:0]                     code_nxt_s;

`ifdef UPC_MARQUEE_ERR_BLINK_EN
   logic phase_r;
   assign err_on_s = phase_r;
`else
   assign err_on_s = 1'b0;
`endif

   // Next-state, load detection, divider and scroll offset.
   always_comb begin
      load_s       = (sync2_r != code_r) || load_pend_r;
      code_nxt_s   = load_s ? sync2_r : code_r;
      state_nxt_s  = ST_BLANK;
      if (name_len(code_nxt_s) == 4'd0) begin
         state_nxt_s = ST_BLANK;
      end else if (scroll_en) begin
         state_nxt_s = ST_SCROLL;
      end else begin
         state_nxt_s = ST_STATIC;
      end
      mode_chg_s   = ((state_r == ST_STATIC) && (state_nxt_s == ST_SCROLL)) ||
                     ((state_r == ST_SCROLL) && (state_nxt_s == ST_STATIC));
      tick_s       = (div_r == DIV_W'(TICK_DIV - 1));
      last_s       = (int'(offset_r) == (int'(name_len(code_r)) + NUM_DIGITS - 1));
      offset_nxt_s = offset_r;
      div_nxt_s    = div_r;
      wrap_nxt_s   = 1'b0;
      if (load_s || mode_chg_s) begin
         offset_nxt_s = '0;
         div_nxt_s    = '0;
      end else begin
         div_nxt_s = tick_s ? '0 : div_r + DIV_W'(1);
         if ((state_r == ST_SCROLL) && tick_s && !freeze) begin
            if (last_s) begin
               offset_nxt_s = '0;
               wrap_nxt_s   = 1'b1;
            end else begin
               offset_nxt_s = offset_r + OFF_W'(1);
            end
         end else begin
            offset_nxt_s = offset_r;
         end
      end
   end

   // Display image built from the current state, code and offset.
   always_comb begin
      disp_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         disp_s[i*LETTER_W +: LETTER_W] = digit_char(state_r, code_r, offset_r, i, err_on_s);
      end
   end

   // Synchroniser, state register and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r     <= 3'd0;
         sync2_r     <= 3'd0;
         code_r      <= 3'd0;
         load_pend_r <= 1'b1;
         state_r     <= ST_BLANK;
         offset_r    <= '0;
         div_r       <= '0;
         wrap_r      <= 1'b0;
         valid_r     <= 1'b0;
         letters_r   <= {NUM_DIGITS{BLANK_CH}};
      end else begin
         sync1_r     <= upc;
         sync2_r     <= sync1_r;
         code_r      <= code_nxt_s;
         load_pend_r <= 1'b0;
         state_r     <= state_nxt_s;
         offset_r    <= offset_nxt_s;
         div_r       <= div_nxt_s;
         wrap_r      <= wrap_nxt_s;
         valid_r     <= (state_r != ST_BLANK);
         letters_r   <= disp_s;
      end
   end

`ifdef UPC_MARQUEE_ERR_BLINK_EN
   // Blink phase: back to ON at every load, toggled on each tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_r <= 1'b1;
      end else if (load_s) begin
         phase_r <= 1'b1;
      end else if (tick_s) begin
         phase_r <= ~phase_r;
      end else begin
         phase_r <= phase_r;
      end
   end
`endif

   assign letters = letters_r;
   assign valid   = valid_r;
   assign wrap    = wrap_r;

endmodule

// File: tb/tb_upc_marquee.sv
// Randomised self-checking bench for upc_marquee against a string-based behavioural model.
module tb_upc_marquee;

   localparam int ND = 6;
   localparam int TD = 4;
   localparam int LW = 5;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [2:0]      upc = 3'b001;
   logic            scroll_en = 1'b0;
   logic            freeze = 1'b0;
   logic [ND*LW-1:0] letters;
   logic            valid;
   logic            wrap;

   int n_cmp = 0;
   int n_err = 0;
   int wrap_seen = 0;

   // model state
   int m_sa, m_sb, m_code, m_mode, m_off, m_cnt;
   bit m_loadp, m_phase;
   int exp_let [ND];
   bit exp_valid, exp_wrap;

   upc_marquee #(.NUM_DIGITS(ND), .TICK_DIV(TD), .LETTER_W(LW)) dut (
      .clk(clk), .reset_n(reset_n), .upc(upc), .scroll_en(scroll_en),
      .freeze(freeze), .letters(letters), .valid(valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic string item_name(int c);
      case (c)
         0: return "DRUGS";
         1: return "CANDY";
         3: return "SOAP";
         4: return "IPHONE";
         5: return "DROID";
         6: return "LEDS";
         default: return "";
      endcase
   endfunction

   // mode: 0 = nothing shown, 1 = static name, 2 = scrolling sequence
   function automatic int model_digit(int i);
      string s;
      string e;
      int len, p;
      s = item_name(m_code);
      e = "ERR";
      len = s.len();
      if (m_mode == 1) begin
         return (i < len) ? int'(s[i]) - 65 : 26;
      end else if (m_mode == 2) begin
         p = (m_off + i) % (len + ND);
         return (p < len) ? int'(s[p]) - 65 : 26;
      end
`ifdef UPC_MARQUEE_ERR_BLINK_EN
      if (m_phase && i < 3) return int'(e[i]) - 65;
`endif
      return 26;
   endfunction

   task automatic model_reset();
      m_sa = 0; m_sb = 0; m_code = 0; m_mode = 0; m_off = 0; m_cnt = 0;
      m_loadp = 1'b1; m_phase = 1'b1;
      for (int i = 0; i < ND; i++) exp_let[i] = 26;
      exp_valid = 1'b0; exp_wrap = 1'b0;
   endtask

   task automatic model_step();
      int nc, nmode, l;
      bit ld, rp, tick;
      exp_valid = (m_mode != 0);
      for (int i = 0; i < ND; i++) exp_let[i] = model_digit(i);
      ld    = (m_sb != m_code) || m_loadp;
      nc    = ld ? m_sb : m_code;
      nmode = (item_name(nc).len() == 0) ? 0 : (scroll_en ? 2 : 1);
      rp    = ld || (m_mode != 0 && nmode != 0 && m_mode != nmode);
      tick  = (m_cnt == TD - 1);
      l     = item_name(m_code).len() + ND;
      exp_wrap = 1'b0;
      if (rp) begin
         m_off = 0;
         m_cnt = 0;
      end else begin
         m_cnt = (m_cnt + 1) % TD;
         if (m_mode == 2 && tick && !freeze) begin
            m_off = (m_off + 1) % l;
            exp_wrap = (m_off == 0);
         end
      end
      if (ld) m_phase = 1'b1;
      else if (tick) m_phase = !m_phase;
      m_sb = m_sa; m_sa = int'(upc); m_code = nc; m_mode = nmode; m_loadp = 1'b0;
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         if (reset_n) model_step();
         #1;
      end
   endtask

   task automatic check_lit(string nm, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      for (int i = 0; i < ND; i++) begin
         n_cmp++;
         if (int'(letters[i*LW +: LW]) != exp_let[i]) begin
            n_err++;
            $display("FAIL letters[%0d] t=%0t: got %0d, expected %0d", i, $time, letters[i*LW +: LW], exp_let[i]);
         end
      end
      n_cmp++;
      if (valid !== exp_valid) begin
         n_err++;
         $display("FAIL valid t=%0t: got %b, expected %b", $time, valid, exp_valid);
      end
      n_cmp++;
      if (wrap !== exp_wrap) begin
         n_err++;
         $display("FAIL wrap t=%0t: got %b, expected %b", $time, wrap, exp_wrap);
      end
      if (wrap === 1'b1) wrap_seen++;
   end

   initial begin
      int hold, guard;
      logic [2:0] save;
      model_reset();
      #12 reset_n = 1'b1;

      // static CANDY
      step(4);
      check_lit("candy_static", 32'(letters), 32'({5'd26, 5'd24, 5'd3, 5'd13, 5'd0, 5'd2}));
      check_lit("candy_valid", 32'(valid), 32'd1);
      step(10);

      // scrolling LEDS, two wraps in 90 edges
      upc = 3'b110; scroll_en = 1'b1; wrap_seen = 0;
      step(4);
      check_lit("leds_off0", 32'(letters), 32'({5'd26, 5'd26, 5'd18, 5'd3, 5'd4, 5'd11}));
      step(86);
      check_lit("wrap_count", 32'(wrap_seen), 32'd2);

      // freeze mid-scroll
      step(7);
      freeze = 1'b1; step(20);
      freeze = 1'b0; step(20);

      // valid to invalid during scroll
      upc = 3'b100; step(20);
      upc = 3'b010; step(4);
      check_lit("invalid_valid", 32'(valid), 32'd0);
      step(12);

      // change landing on a tick edge
      upc = 3'b101; step(10);
      guard = 0;
      while (m_cnt != 1 && guard < 10) begin
         step(1);
         guard++;
      end
      check_lit("tick_align", 32'(m_cnt), 32'd1);
      upc = 3'b011; step(16);

      // asynchronous reset mid-scroll
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check_lit("rst_letters", 32'(letters), 32'({6{5'd26}}));
      check_lit("rst_valid", 32'(valid), 32'd0);
      check_lit("rst_wrap", 32'(wrap), 32'd0);
      step(2);
      reset_n = 1'b1;
      step(8);

      // randomised traffic with occasional sub-cycle glitches
      for (int seg = 0; seg < 60; seg++) begin
         upc = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) scroll_en = ~scroll_en;
         hold = $urandom_range(1, 40);
         for (int k = 0; k < hold; k++) begin
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) begin
               save = upc;
               upc = 3'($urandom_range(0, 7));
               #2 upc = save;
            end
            step(1);
         end
      end

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
